serial_rx_fifo: RTL
===================

SERIAL_RX_FIFO -- requirements
Module: serial_rx_fifo

Interface
REQ-001 SHALL have parameter BITS, default 8, word width, matching the serial receiver's BITS.
REQ-002 SHALL have parameter ADDR_BITS, default 4, FIFO depth = 2**ADDR_BITS words.
REQ-003 SHALL have port in_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port in_rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port in_enable, input, 1, capture enable for incoming words.
REQ-006 SHALL have port in_parallel, input, BITS, received word from the serial receiver's out_parallel.
REQ-007 SHALL have port in_next_word, input, 1, word-complete level from the receiver's out_next_word.
REQ-008 SHALL have port in_read, input, 1, pop request from the consumer.
REQ-009 SHALL have port in_clear_overflow, input, 1, clears the sticky overflow flag.
REQ-010 SHALL have port out_parallel, output, BITS, head-of-FIFO word (show-ahead).
REQ-011 SHALL have port out_valid, output, 1, high when out_parallel holds a valid word; equals ~out_empty.
REQ-012 SHALL have port out_empty, output, 1, FIFO holds 0 words.
REQ-013 SHALL have port out_full, output, 1, FIFO holds 2**ADDR_BITS words.
REQ-014 SHALL have port out_count, output, ADDR_BITS+1, number of words held.
REQ-015 SHALL have port out_overflow, output, 1, sticky flag: a word was dropped.

Function
REQ-016 Edge detect: register last_next_word SHALL sample in_next_word every cycle, independent of in_enable.
REQ-017 Capture event SHALL be in_next_word=1 and last_next_word=0 and in_enable=1, sampled on the same clock edge.
REQ-018 On capture with FIFO not full, in_parallel SHALL be written to mem[wr_ptr]; wr_ptr increments.
REQ-019 Written word SHALL be visible on out_parallel, with out_valid=1, in the cycle after the capture edge (latency 1).
REQ-020 Pop SHALL occur when in_read=1 and out_empty=0; rd_ptr increments and the next word appears the following cycle.
REQ-021 in_read while empty SHALL be ignored: no pointer change, no error flag.
REQ-022 wr_ptr and rd_ptr SHALL be ADDR_BITS wide and wrap from 2**ADDR_BITS-1 to 0.
REQ-023 out_count SHALL be +1 on a write only, -1 on a pop only, and unchanged on write plus pop or on neither.
REQ-024 Full with capture and a simultaneous pop: the pop SHALL occur, the write SHALL be accepted, count stays at max, no overflow.
REQ-025 Full with capture and no pop: the word SHALL be dropped, memory and pointers unchanged, out_overflow set to 1 next cycle.
REQ-026 Empty with capture and in_read in the same cycle: the write SHALL be accepted, the read ignored, count 0 -> 1.
REQ-027 out_overflow SHALL clear on in_clear_overflow=1; a new overflow in the same cycle SHALL win, leaving it 1.
REQ-028 in_next_word held high for many cycles SHALL produce exactly one capture.
REQ-029 in_next_word rising while in_enable=0 SHALL not produce a capture, even if in_enable rises later while in_next_word is still high.
REQ-030 out_parallel SHALL be registered read data or mem[rd_ptr]; its value when out_empty=1 is don't-care.

Reset
REQ-031 While in_rst=0, wr_ptr, rd_ptr and out_count SHALL be 0, out_empty=1, out_valid=0, out_full=0, out_overflow=0.
REQ-032 last_next_word SHALL reset to 1, so in_next_word high at reset release causes no spurious capture.
REQ-033 Reset asserted mid-operation SHALL discard all stored words immediately; memory contents need not be cleared.

Verification
REQ-034 Capture 8'hff, 8'h11, 8'h01, 8'h10 with in_enable=1, no reads -> out_count=4, out_parallel=8'hff; four pops return ff, 11, 01, 10, then out_empty=1.
REQ-035 Write 16 words 0x00..0x0f (ADDR_BITS=4), then a 17th word 0xaa -> out_full=1, out_overflow=1, pops return 0x00..0x0f only.
REQ-036 Full FIFO, capture 0x55 with in_read=1 -> count stays 16, no overflow; after draining, last word read is 0x55.
REQ-037 in_next_word held high 10 cycles, then in_enable toggled 0->1 while still high -> exactly one word stored.
REQ-038 Set overflow, then assert in_clear_overflow with a simultaneous dropped write -> out_overflow stays 1; next clear alone -> 0.
REQ-039 Reset pulse (in_rst=0) with 5 words stored and in_next_word=1 -> after release, out_count=0, out_empty=1, no capture until the next rising edge of in_next_word.

Source files
------------

// File: rtl/serial_rx_fifo.sv
// Show-ahead receive FIFO behind a serial receiver: captures one word per rising
// edge of in_next_word (when enabled) and flags words dropped while full.
module serial_rx_fifo #(
    parameter int BITS      = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_enable,
    input  logic [BITS-1:0]      in_parallel,
    input  logic                 in_next_word,
    input  logic                 in_read,
    input  logic                 in_clear_overflow,
    output logic [BITS-1:0]      out_parallel,
    output logic                 out_valid,
    output logic                 out_empty,
    output logic                 out_full,
    output logic [ADDR_BITS:0]   out_count,
    output logic                 out_overflow
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] COUNT_MAX = (ADDR_BITS+1)'(DEPTH);

    logic [BITS-1:0]      mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic                 last_next_word;
    logic                 overflow;

    logic capture;
    logic pop;
    logic wr_en;
    logic drop;

    assign out_empty = (count == '0);
    assign out_full  = (count == COUNT_MAX);
    assign out_valid = ~out_empty;
    assign out_count = count;
    assign out_overflow = overflow;
    assign out_parallel = mem[rd_ptr];

    // A full FIFO still accepts a capture when the same cycle frees a slot.
    assign capture = in_next_word & ~last_next_word & in_enable;
    assign pop     = in_read & ~out_empty;
    assign wr_en   = capture & (~out_full | pop);
    assign drop    = capture & out_full & ~pop;

    // NOTE: storage has no reset; emptiness is defined purely by the pointers and count.
    always_ff @(posedge in_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_parallel;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            last_next_word <= 1'b1;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            overflow       <= 1'b0;
        end else begin
            last_next_word <= in_next_word;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear request leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (in_clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
